// File: rtl/network_packet_assembler.sv
// Reassembles typed header/body/tail flits into one wide packet word.
// Define NETWORK_PACKET_ASSEMBLER_TIMEOUT_EN to abandon stalled partial packets.
module network_packet_assembler #(
  parameter int unsigned FlitWidth         = 64,
  parameter int unsigned MaxFlitsPerPacket = 4,
  parameter int unsigned TimeoutCycles     = 256
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [FlitWidth-1:0]                   flit_i,
  input  logic [1:0]                             flit_type_i,
  input  logic                                   flit_valid_i,
  output logic                                   flit_ready_o,
  output logic [FlitWidth*MaxFlitsPerPacket-1:0] packet_data_o,
  output logic [$clog2(MaxFlitsPerPacket+1)-1:0] packet_len_o,
  output logic                                   packet_trunc_o,
  output logic                                   packet_valid_o,
  input  logic                                   packet_ready_i,
  output logic                                   error_o
);

  localparam int unsigned LenW  = $clog2(MaxFlitsPerPacket + 1);
  localparam int unsigned DataW = FlitWidth * MaxFlitsPerPacket;

  localparam logic [1:0] TypeHead     = 2'b00;
  localparam logic [1:0] TypeTail     = 2'b10;
  localparam logic [1:0] TypeHeadTail = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [DataW-1:0] data_q, data_d;
  logic [LenW-1:0]  len_q, len_d;
  logic             trunc_q, trunc_d;
  logic             error_q, error_d;
  logic             flit_hs;
  logic             is_head;

`ifdef NETWORK_PACKET_ASSEMBLER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  // Ready is held low while reset is asserted, then tracks the state.
  assign flit_ready_o = rst_ni & (state_q != HOLD);
  assign flit_hs      = flit_valid_i & flit_ready_o;
  assign is_head      = (flit_type_i == TypeHead) |
                        (flit_type_i == TypeHeadTail);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    trunc_d = trunc_q;
    error_d = 1'b0;
`ifdef NETWORK_PACKET_ASSEMBLER_TIMEOUT_EN
    cnt_d   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (flit_hs) begin
          if (is_head) begin
            data_d                  = '0;
            data_d[FlitWidth-1:0]   = flit_i;
            len_d                   = LenW'(1);
            trunc_d                 = 1'b0;
            state_d = (flit_type_i == TypeHeadTail) ? HOLD : COLLECT;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (flit_hs) begin
          if (is_head) begin
            error_d                 = 1'b1;
            data_d                  = '0;
            data_d[FlitWidth-1:0]   = flit_i;
            len_d                   = LenW'(1);
            trunc_d                 = 1'b0;
            state_d = (flit_type_i == TypeHeadTail) ? HOLD : COLLECT;
          end else begin
            if (len_q < LenW'(MaxFlitsPerPacket)) begin
              for (int k = 0; k < int'(MaxFlitsPerPacket); k++) begin
                if (len_q == LenW'(k)) begin
                  data_d[k*FlitWidth +: FlitWidth] = flit_i;
                end
              end
              len_d = len_q + LenW'(1);
            end else begin
              trunc_d = 1'b1;
            end
            if (flit_type_i == TypeTail) begin
              state_d = HOLD;
            end
          end
        end
`ifdef NETWORK_PACKET_ASSEMBLER_TIMEOUT_EN
        else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      HOLD: begin
        if (packet_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      data_q  <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
      error_q <= 1'b0;
`ifdef NETWORK_PACKET_ASSEMBLER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      trunc_q <= trunc_d;
      error_q <= error_d;
`ifdef NETWORK_PACKET_ASSEMBLER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign packet_valid_o = (state_q == HOLD);
  assign packet_data_o  = data_q;
  assign packet_len_o   = len_q;
  assign packet_trunc_o = trunc_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_network_packet_assembler.sv
// Directed bench for network_packet_assembler.
// Honours NETWORK_PACKET_ASSEMBLER_TIMEOUT_EN for the stall scenario.
module tb_network_packet_assembler;

  localparam int FW = 64;
  localparam int MX = 4;
  localparam int DW = FW * MX;
  localparam int LW = 3;

  localparam logic [1:0] HDR = 2'b00;
  localparam logic [1:0] BDY = 2'b01;
  localparam logic [1:0] TL  = 2'b10;
  localparam logic [1:0] HT  = 2'b11;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [FW-1:0] flit_i;
  logic [1:0]    flit_type_i;
  logic          flit_valid_i;
  logic          flit_ready_o;
  logic [DW-1:0] packet_data_o;
  logic [LW-1:0] packet_len_o;
  logic          packet_trunc_o;
  logic          packet_valid_o;
  logic          packet_ready_i;
  logic          error_o;

  always #5 clk = ~clk;

  network_packet_assembler #(
    .FlitWidth        (FW),
    .MaxFlitsPerPacket(MX),
    .TimeoutCycles    (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .flit_i        (flit_i),
    .flit_type_i   (flit_type_i),
    .flit_valid_i  (flit_valid_i),
    .flit_ready_o  (flit_ready_o),
    .packet_data_o (packet_data_o),
    .packet_len_o  (packet_len_o),
    .packet_trunc_o(packet_trunc_o),
    .packet_valid_o(packet_valid_o),
    .packet_ready_i(packet_ready_i),
    .error_o       (error_o)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int err_cnt = 0;
  int pkt_cnt = 0;
  logic [DW-1:0] pkt_data;
  logic [LW-1:0] pkt_len;
  logic          pkt_trunc;

  always @(negedge clk) begin
    if (error_o) err_cnt <= err_cnt + 1;
    if (packet_valid_o && packet_ready_i) begin
      pkt_cnt   <= pkt_cnt + 1;
      pkt_data  <= packet_data_o;
      pkt_len   <= packet_len_o;
      pkt_trunc <= packet_trunc_o;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [FW-1:0] slot(input int k);
    return pkt_data[k*FW +: FW];
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] t, input logic [FW-1:0] d);
    int n = 0;
    flit_type_i  = t;
    flit_i       = d;
    flit_valid_i = 1'b1;
    while (!flit_ready_o && n < 50) begin
      idle(1);
      n++;
    end
    if (n >= 50) check("send_wait", 0, 1);
    idle(1);
    flit_valid_i = 1'b0;
  endtask

  task automatic wait_pkt(input int base);
    int n = 0;
    while (pkt_cnt == base && n < 50) begin
      idle(1);
      n++;
    end
    if (pkt_cnt == base) check("pkt_wait", 0, 1);
  endtask

  int e0, p0;

  initial begin
    rst_ni         = 1'b0;
    flit_i         = '0;
    flit_type_i    = HDR;
    flit_valid_i   = 1'b0;
    packet_ready_i = 1'b0;
    #2;
    check("rst_ready", flit_ready_o, 0);
    check("rst_valid", packet_valid_o, 0);
    check("rst_error", error_o, 0);
    check("rst_len", packet_len_o, 0);
    check("rst_data", packet_data_o, 0);
    check("rst_trunc", packet_trunc_o, 0);
    @(posedge clk);
    #1;
    idle(2);
    rst_ni = 1'b1;
    #1;
    check("rel_ready", flit_ready_o, 1);

    // basic three-flit packet
    packet_ready_i = 1'b1;
    e0 = err_cnt;
    p0 = pkt_cnt;
    send(HDR, 64'hAAAA_0000_0000_000A);
    send(BDY, 64'hBBBB_0000_0000_000B);
    send(TL,  64'hCCCC_0000_0000_000C);
    wait_pkt(p0);
    check("t1_len", pkt_len, 3);
    check("t1_s0", slot(0), 64'hAAAA_0000_0000_000A);
    check("t1_s1", slot(1), 64'hBBBB_0000_0000_000B);
    check("t1_s2", slot(2), 64'hCCCC_0000_0000_000C);
    check("t1_s3", slot(3), 0);
    check("t1_trunc", pkt_trunc, 0);
    check("t1_err", err_cnt - e0, 0);

    // header_tail held under backpressure
    packet_ready_i = 1'b0;
    p0 = pkt_cnt;
    send(HT, 64'hDEAD);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_valid", packet_valid_o, 1);
      check("t2_ready", flit_ready_o, 0);
      check("t2_data", packet_data_o, {192'd0, 64'hDEAD});
      check("t2_len", packet_len_o, 1);
    end
    @(posedge clk);
    #1;
    check("t2_nopkt", pkt_cnt - p0, 0);
    packet_ready_i = 1'b1;
    idle(1);
    check("t2_pkt", pkt_cnt - p0, 1);
    check("t2_valid_off", packet_valid_o, 0);
    check("t2_ready_on", flit_ready_o, 1);

    // overflow truncation
    e0 = err_cnt;
    p0 = pkt_cnt;
    send(HDR, 64'd1);
    for (int i = 2; i <= 6; i++) send(BDY, 64'(i));
    send(TL, 64'd7);
    wait_pkt(p0);
    check("t3_len", pkt_len, 4);
    check("t3_s0", slot(0), 1);
    check("t3_s1", slot(1), 2);
    check("t3_s2", slot(2), 3);
    check("t3_s3", slot(3), 4);
    check("t3_trunc", pkt_trunc, 1);
    check("t3_err", err_cnt - e0, 0);

    // body in idle, then header restart
    e0 = err_cnt;
    p0 = pkt_cnt;
    send(BDY, 64'h99);
    idle(3);
    check("t4_err", err_cnt - e0, 1);
    check("t4_nopkt", pkt_cnt - p0, 0);
    e0 = err_cnt;
    p0 = pkt_cnt;
    send(HDR, 64'h1234);
    send(BDY, 64'h5678);
    send(HDR, 64'hFEED);
    send(TL,  64'hBEEF);
    wait_pkt(p0);
    check("t4_restart_err", err_cnt - e0, 1);
    check("t4_len", pkt_len, 2);
    check("t4_s0", slot(0), 64'hFEED);
    check("t4_s1", slot(1), 64'hBEEF);
    check("t4_s2", slot(2), 0);
    check("t4_trunc", pkt_trunc, 0);

    // reset mid-packet
    send(HDR, 64'h11);
    send(BDY, 64'h22);
    rst_ni = 1'b0;
    #1;
    check("t5_valid", packet_valid_o, 0);
    check("t5_ready", flit_ready_o, 0);
    check("t5_len", packet_len_o, 0);
    check("t5_data", packet_data_o, 0);
    check("t5_error", error_o, 0);
    idle(1);
    rst_ni = 1'b1;
    #1;
    e0 = err_cnt;
    p0 = pkt_cnt;
    send(TL, 64'h33);
    idle(3);
    check("t5_tail_err", err_cnt - e0, 1);
    check("t5_nopkt", pkt_cnt - p0, 0);

    // stalled partial packet
    e0 = err_cnt;
    p0 = pkt_cnt;
    send(HDR, 64'h55);
    idle(10);
    send(TL, 64'h66);
`ifdef NETWORK_PACKET_ASSEMBLER_TIMEOUT_EN
    idle(3);
    check("t6_err", err_cnt - e0, 2);
    check("t6_nopkt", pkt_cnt - p0, 0);
`else
    wait_pkt(p0);
    check("t6_err", err_cnt - e0, 0);
    check("t6_len", pkt_len, 2);
    check("t6_s0", slot(0), 64'h55);
    check("t6_s1", slot(1), 64'h66);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
